regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined core.
//  N read ports, M write ports, same-cycle write-to-read bypass, and an

---
 rtl/liang_pkg.sv | 23 ++
 rtl/regfile_mp_if.sv | 28 ++
 rtl/rf_scoreboard.sv | 57 +++++
 rtl/regfile_mp.sv | 131 +++++++++++++
 tb/tb_regfile_mp.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/liang_pkg.sv
// Shared types and helpers for the multi-port register file.
// rf_prio_sel picks the winning write port when several target one address.
package liang_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_A0_IDX    = 10;
  localparam int RF_MAX_PORTS = 8;

  // Highest set request index wins; -1 when nothing requests.
  function automatic int rf_prio_sel(input logic [RF_MAX_PORTS-1:0] req);
    int sel;
    sel = -1;
    for (int k = 0; k < RF_MAX_PORTS; k++) begin
      if (req[k]) sel = k;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bundle between issue/writeback (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int AW = 5,
  parameter int DW = 64,
  parameter int NR = 2,
  parameter int NW = 2
);
  logic             ready;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic [NW-1:0]    wen;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic             set_en;
  logic [AW-1:0]    set_addr;
  logic [DW-1:0]    a0;

  modport master (
    input  ready, rdata, rbusy, a0,
    output raddr, wen, waddr, wdata, set_en, set_addr
  );

  modport slave (
    output ready, rdata, rbusy, a0,
    input  raddr, wen, waddr, wdata, set_en, set_addr
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: set on dispatch, cleared on writeback, set beats clear.
// Read side exposes a same-cycle clear but hides a same-cycle set.
module rf_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int NR_READ    = 2,
  parameter int NR_WRITE   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NR_WRITE-1:0]          i_wen,
  input  logic [NR_WRITE*ADDR_WIDTH-1:0] i_waddr,
  input  logic                         i_set_en,
  input  logic [ADDR_WIDTH-1:0]        i_set_addr,
  input  logic [NR_READ*ADDR_WIDTH-1:0] i_raddr,
  output logic [NR_READ-1:0]           o_rbusy
);
  localparam int AW   = ADDR_WIDTH;
  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREG-1:0] w_busy;
  logic [NREG-1:0] w_clr;

  assign w_busy[0] = 1'b0;
  assign w_clr[0]  = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_bit
    logic r_busy;
    logic w_hit;

    always_comb begin
      w_hit = 1'b0;
      for (int j = 0; j < NR_WRITE; j++) begin
        if (i_wen[j] && (i_waddr[j*AW +: AW] == AW'(gi))) w_hit = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_busy <= 1'b0;
      end else if (i_set_en && (i_set_addr == AW'(gi))) begin
        r_busy <= 1'b1;
      end else if (w_hit) begin
        r_busy <= 1'b0;
      end
    end

    assign w_busy[gi] = r_busy;
    assign w_clr[gi]  = w_hit;
  end

  for (genvar gi = 0; gi < NR_READ; gi++) begin : g_rd
    logic [AW-1:0] w_addr;
    assign w_addr      = i_raddr[gi*AW +: AW];
    assign o_rbusy[gi] = w_busy[w_addr] & ~w_clr[w_addr];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, busy scoreboard and a
// post-reset sequencer that zeroes one entry per cycle before going live.
module regfile_mp
  import liang_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR_READ    = 2,
  parameter int NR_WRITE   = 2
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int AW   = ADDR_WIDTH;
  localparam int DW   = DATA_WIDTH;
  localparam int NREG = 2 ** ADDR_WIDTH;

  rf_state_e           r_state;
  logic [AW-1:0]       r_cnt;
  logic                r_ready;
  logic                w_run;
  logic [NR_WRITE-1:0] w_wen;
  logic                w_set_en;
  logic [NR_READ-1:0]  w_rbusy;
  logic [DW-1:0]       w_mem [NREG];

  assign w_run    = (r_state == RF_RUN);
  assign w_wen    = bus.wen & {NR_WRITE{w_run}};
  assign w_set_en = bus.set_en & w_run;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_INIT;
      r_cnt   <= AW'(1);
      r_ready <= 1'b0;
    end else if (r_state == RF_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == AW'(NREG - 1)) begin
        r_state <= RF_RUN;
        r_ready <= 1'b1;
      end
    end
  end

  // x0 has no storage; it reads as zero everywhere.
  assign w_mem[0] = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_entry
    logic [RF_MAX_PORTS-1:0] w_hit;
    int                      w_sel;
    logic [DW-1:0]           w_data;
    logic [DW-1:0]           r_val;

    for (genvar gj = 0; gj < RF_MAX_PORTS; gj++) begin : g_hit
      if (gj < NR_WRITE) begin : g_port
        assign w_hit[gj] = w_wen[gj] && (bus.waddr[gj*AW +: AW] == AW'(gi));
      end else begin : g_pad
        assign w_hit[gj] = 1'b0;
      end
    end

    assign w_sel = rf_prio_sel(w_hit);

    always_comb begin
      w_data = '0;
      for (int j = 0; j < NR_WRITE; j++) begin
        if (w_sel == j) w_data = bus.wdata[j*DW +: DW];
      end
    end

    always_ff @(posedge clk) begin
      if (r_state == RF_INIT) begin
        if (r_cnt == AW'(gi)) r_val <= '0;
      end else if (w_sel >= 0) begin
        r_val <= w_data;
      end
    end

    assign w_mem[gi] = r_val;
  end

  for (genvar gi = 0; gi < NR_READ; gi++) begin : g_rd
    logic [AW-1:0]           w_addr;
    logic [RF_MAX_PORTS-1:0] w_hit;
    int                      w_sel;
    logic [DW-1:0]           w_data;

    assign w_addr = bus.raddr[gi*AW +: AW];

    for (genvar gj = 0; gj < RF_MAX_PORTS; gj++) begin : g_hit
      if (gj < NR_WRITE) begin : g_port
        assign w_hit[gj] = w_wen[gj] && (bus.waddr[gj*AW +: AW] == w_addr);
      end else begin : g_pad
        assign w_hit[gj] = 1'b0;
      end
    end

    assign w_sel = rf_prio_sel(w_hit);

    // Write-first: a same-cycle write to this address overrides the array.
    always_comb begin
      w_data = w_mem[w_addr];
      for (int j = 0; j < NR_WRITE; j++) begin
        if (w_sel == j) w_data = bus.wdata[j*DW +: DW];
      end
    end

    assign bus.rdata[gi*DW +: DW] = (w_run && (w_addr != '0)) ? w_data : '0;
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NR_READ    (NR_READ),
    .NR_WRITE   (NR_WRITE)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_wen      (w_wen),
    .i_waddr    (bus.waddr),
    .i_set_en   (w_set_en),
    .i_set_addr (bus.set_addr),
    .i_raddr    (bus.raddr),
    .o_rbusy    (w_rbusy)
  );

  assign bus.rbusy = w_rbusy & {NR_READ{w_run}};
  assign bus.ready = r_ready;
  assign bus.a0    = w_run ? w_mem[RF_A0_IDX] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init timing, bypass, port priority, x0,
// scoreboard set/clear ordering and reset during init.
module tb_regfile_mp;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc;

  regfile_mp_if #(.AW(AW), .DW(DW), .NR(NR), .NW(NW)) bus ();

  regfile_mp #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NR_READ    (NR),
    .NR_WRITE   (NW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("[%0t] %s: 0x%0h ok", $time, tag, got);
    end else begin
      $display("[%0t] FAIL %s: got 0x%0h expected 0x%0h", $time, tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wen    = '0;
    bus.set_en = 1'b0;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wen[p]            = 1'b1;
    bus.waddr[p*AW +: AW] = a;
    bus.wdata[p*DW +: DW] = d;
  endtask

  task automatic rd_addr(input int p, input logic [AW-1:0] a);
    bus.raddr[p*AW +: AW] = a;
  endtask

  task automatic set_busy(input logic [AW-1:0] a);
    bus.set_en   = 1'b1;
    bus.set_addr = a;
  endtask

  function automatic logic [DW-1:0] rdat(input int p);
    return bus.rdata[p*DW +: DW];
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < 200) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.wen      = '0;
    bus.waddr    = '0;
    bus.wdata    = '0;
    bus.set_en   = 1'b0;
    bus.set_addr = '0;
    bus.raddr    = '0;
    step();
    step();
    chk("rst_ready", 64'(bus.ready), 64'd0);

    // Release reset and time the init sweep.
    rst = 1'b0;
    rd_addr(0, 5);
    #1;
    chk("init_rdata", rdat(0), 64'd0);
    chk("init_rbusy", 64'(bus.rbusy), 64'd0);
    chk("init_a0", bus.a0, 64'd0);
    wait_ready(cyc);
    chk("ready_latency", 64'(cyc), 64'd31);

    for (int a = 0; a < 32; a++) begin
      rd_addr(0, AW'(a));
      rd_addr(1, AW'(31 - a));
      #1;
      chk($sformatf("cleared_p0_x%0d", a), rdat(0), 64'd0);
      chk($sformatf("cleared_p1_x%0d", 31 - a), rdat(1), 64'd0);
    end

    // Same-cycle bypass then stored value.
    wr(0, 5, 64'hDEAD);
    rd_addr(0, 5);
    #1;
    chk("bypass_x5", rdat(0), 64'hDEAD);
    step();
    idle();
    #1;
    chk("stored_x5", rdat(0), 64'hDEAD);

    // Both write ports to x7: higher port wins.
    wr(0, 7, 64'h11);
    wr(1, 7, 64'h22);
    rd_addr(0, 7);
    rd_addr(1, 7);
    #1;
    chk("prio_bypass_p0", rdat(0), 64'h22);
    chk("prio_bypass_p1", rdat(1), 64'h22);
    step();
    idle();
    #1;
    chk("prio_stored_x7", rdat(1), 64'h22);

    // Independent writes; a0 has no bypass.
    wr(0, 10, 64'hA0A0);
    wr(1, 11, 64'hB1);
    rd_addr(0, 10);
    rd_addr(1, 11);
    #1;
    chk("bypass_x10", rdat(0), 64'hA0A0);
    chk("bypass_x11", rdat(1), 64'hB1);
    chk("a0_no_bypass", bus.a0, 64'd0);
    step();
    idle();
    #1;
    chk("a0_after_write", bus.a0, 64'hA0A0);
    chk("stored_x11", rdat(1), 64'hB1);

    // x0 ignores writes and busy sets.
    wr(1, 0, 64'hFF);
    set_busy(0);
    rd_addr(0, 0);
    #1;
    chk("x0_bypass", rdat(0), 64'd0);
    chk("x0_rbusy_now", 64'(bus.rbusy[0]), 64'd0);
    step();
    idle();
    #1;
    chk("x0_stored", rdat(0), 64'd0);
    chk("x0_rbusy_next", 64'(bus.rbusy[0]), 64'd0);

    // Scoreboard ordering on x3.
    set_busy(3);
    rd_addr(0, 3);
    rd_addr(1, 4);
    #1;
    chk("set_not_visible", 64'(bus.rbusy[0]), 64'd0);
    step();
    idle();
    #1;
    chk("set_visible_x3", 64'(bus.rbusy[0]), 64'd1);
    chk("other_not_busy_x4", 64'(bus.rbusy[1]), 64'd0);
    wr(0, 3, 64'h33);
    set_busy(3);
    #1;
    chk("clear_bypass_x3", 64'(bus.rbusy[0]), 64'd0);
    chk("data_bypass_x3", rdat(0), 64'h33);
    step();
    idle();
    #1;
    chk("set_beats_clear", 64'(bus.rbusy[0]), 64'd1);
    wr(0, 3, 64'h34);
    #1;
    chk("clear_now_x3", 64'(bus.rbusy[0]), 64'd0);
    step();
    idle();
    #1;
    chk("cleared_x3", 64'(bus.rbusy[0]), 64'd0);
    chk("stored_x3", rdat(0), 64'h34);
    set_busy(3);
    step();
    set_busy(3);
    step();
    idle();
    #1;
    chk("set_twice_x3", 64'(bus.rbusy[0]), 64'd1);

    // Reset, then reset again once the init counter reaches 12.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (11) step();
    chk("mid_init_ready", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr(0, 20, 64'h1234);
    set_busy(21);
    rd_addr(0, 20);
    rd_addr(1, 21);
    #1;
    chk("init_write_rdata", rdat(0), 64'd0);
    chk("init_set_rbusy", 64'(bus.rbusy[1]), 64'd0);
    step();
    idle();
    wait_ready(cyc);
    chk("rerst_latency", 64'(cyc + 1), 64'd31);
    #1;
    chk("lost_write_x20", rdat(0), 64'd0);
    chk("lost_set_x21", 64'(bus.rbusy[1]), 64'd0);
    rd_addr(0, 5);
    rd_addr(1, 3);
    #1;
    chk("reinit_x5", rdat(0), 64'd0);
    chk("reinit_busy_x3", 64'(bus.rbusy[1]), 64'd0);
    chk("reinit_a0", bus.a0, 64'd0);

    // Ports are live again after re-init.
    wr(0, 21, 64'h5);
    step();
    idle();
    rd_addr(0, 21);
    #1;
    chk("post_init_write", rdat(0), 64'h5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
